// File: rtl/bus_arbiter_4.sv
// bus_arbiter_4: round-robin owner of a shared 4:1 mux feeding a registered bus; ARB_TIMEOUT_EN bounds each tenure
module bus_arbiter_4 #(
  parameter int WIDTH    = 4,
  parameter int HOLD_MAX = 8,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] i_0,
  input  logic [WIDTH-1:0] i_1,
  input  logic [WIDTH-1:0] i_2,
  input  logic [WIDTH-1:0] i_3,
  output logic [3:0]       grant,
  output logic             a,
  output logic             b,
  output logic [WIDTH-1:0] bus_out,
  output logic             bus_valid,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, RELEASE = 2'd2} state_t;
  state_t state, state_nxt;
  logic [1:0] last, last_nxt, sel, sel_nxt, pick, cand;
  logic [3:0] grant_nxt;
  logic [WIDTH-1:0] bus_nxt, owner_data;
  logic valid_nxt, found, stop;
  assign a = sel[1];
  assign b = sel[0];
  assign owner_data = last == 2'd0 ? i_0 : last == 2'd1 ? i_1 : last == 2'd2 ? i_2 : i_3;
  // search starts just past the previous owner, so the previous owner is tried last
  always_comb begin
    found = 1'b0;
    pick  = last;
    cand  = last;
    for (int j = 1; j <= 4; j++) begin
      cand = last + 2'(j);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end
`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt;
  // cnt counts words already on the bus, so the owner sees exactly HOLD_MAX valid words
  assign stop = bus_valid && cnt == CNT_W'(HOLD_MAX - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else cnt <= state != GRANT ? '0 : bus_valid ? cnt + 1'b1 : cnt;
`else
  assign stop = 1'b0;
`endif
  always_comb begin
    state_nxt = IDLE;
    grant_nxt = grant;
    sel_nxt   = sel;
    last_nxt  = last;
    bus_nxt   = bus_out;
    valid_nxt = bus_valid;
    case (state)
      IDLE: if (found) begin
        state_nxt = GRANT;
        grant_nxt = 4'b0001 << pick;
        sel_nxt   = pick;
        last_nxt  = pick;
      end
      GRANT: if (req[last] && !stop) begin
        state_nxt = GRANT;
        bus_nxt   = owner_data;
        valid_nxt = 1'b1;
      end else begin
        state_nxt = RELEASE;
        grant_nxt = 4'b0000;
        valid_nxt = 1'b0;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state     <= IDLE;
      grant     <= 4'b0000;
      sel       <= 2'd0;
      last      <= 2'd3;
      bus_out   <= '0;
      bus_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      grant     <= grant_nxt;
      sel       <= sel_nxt;
      last      <= last_nxt;
      bus_out   <= bus_nxt;
      bus_valid <= valid_nxt;
      busy      <= state_nxt != IDLE;
    end
endmodule

// File: tb/tb_bus_arbiter_4.sv
// tb_bus_arbiter_4: directed vector table plus hand sequences for reset, idle hold and tenure timeout
module tb_bus_arbiter_4;
  logic clk = 1'b0, reset = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] i_0 = 4'hA, i_1 = 4'h5, i_2 = 4'hC, i_3 = 4'h3;
  logic [3:0] grant, bus_out;
  logic a, b, bus_valid, busy;
  int n_cmp = 0, n_bad = 0;
  typedef struct {
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] sel;
    logic [3:0] bus;
    logic       valid;
    logic       busy;
  } vec_t;
  vec_t vt[$];
  always #5 clk = ~clk;
  bus_arbiter_4 dut (
    .clk(clk), .reset(reset), .req(req),
    .i_0(i_0), .i_1(i_1), .i_2(i_2), .i_3(i_3),
    .grant(grant), .a(a), .b(b),
    .bus_out(bus_out), .bus_valid(bus_valid), .busy(busy)
  );
  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  task automatic chk_all(input string tag, input logic [3:0] g, input logic [1:0] s,
                         input logic [3:0] bo, input logic v, input logic bz);
    chk({tag, " grant"}, 8'(grant), 8'(g));
    chk({tag, " sel"}, 8'({a, b}), 8'(s));
    chk({tag, " bus_out"}, 8'(bus_out), 8'(bo));
    chk({tag, " bus_valid"}, 8'(bus_valid), 8'(v));
    chk({tag, " busy"}, 8'(busy), 8'(bz));
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic add(input logic [3:0] r, input logic [3:0] g, input logic [1:0] s,
                     input logic [3:0] bo, input logic v, input logic bz);
    vec_t e;
    e.req = r; e.grant = g; e.sel = s; e.bus = bo; e.valid = v; e.busy = bz;
    vt.push_back(e);
  endtask
  initial begin
    // single requester 0 after reset
    add(4'b0001, 4'b0001, 2'd0, 4'h0, 1'b0, 1'b1);
    add(4'b0001, 4'b0001, 2'd0, 4'hA, 1'b1, 1'b1);
    add(4'b0000, 4'b0000, 2'd0, 4'hA, 1'b0, 1'b1);
    add(4'b0000, 4'b0000, 2'd0, 4'hA, 1'b0, 1'b0);
    // all requesting, each owner drops after two words
    add(4'b1111, 4'b0010, 2'd1, 4'hA, 1'b0, 1'b1);
    add(4'b1111, 4'b0010, 2'd1, 4'h5, 1'b1, 1'b1);
    add(4'b1111, 4'b0010, 2'd1, 4'h5, 1'b1, 1'b1);
    add(4'b1101, 4'b0000, 2'd1, 4'h5, 1'b0, 1'b1);
    add(4'b1111, 4'b0000, 2'd1, 4'h5, 1'b0, 1'b0);
    add(4'b1111, 4'b0100, 2'd2, 4'h5, 1'b0, 1'b1);
    add(4'b1111, 4'b0100, 2'd2, 4'hC, 1'b1, 1'b1);
    add(4'b1111, 4'b0100, 2'd2, 4'hC, 1'b1, 1'b1);
    add(4'b1011, 4'b0000, 2'd2, 4'hC, 1'b0, 1'b1);
    add(4'b1111, 4'b0000, 2'd2, 4'hC, 1'b0, 1'b0);
    add(4'b1111, 4'b1000, 2'd3, 4'hC, 1'b0, 1'b1);
    add(4'b1111, 4'b1000, 2'd3, 4'h3, 1'b1, 1'b1);
    add(4'b1111, 4'b1000, 2'd3, 4'h3, 1'b1, 1'b1);
    add(4'b0111, 4'b0000, 2'd3, 4'h3, 1'b0, 1'b1);
    add(4'b1111, 4'b0000, 2'd3, 4'h3, 1'b0, 1'b0);
    add(4'b1111, 4'b0001, 2'd0, 4'h3, 1'b0, 1'b1);
    add(4'b1111, 4'b0001, 2'd0, 4'hA, 1'b1, 1'b1);
    add(4'b0000, 4'b0000, 2'd0, 4'hA, 1'b0, 1'b1);
    add(4'b0000, 4'b0000, 2'd0, 4'hA, 1'b0, 1'b0);
    // owner 2 keeps the bus while requester 1 waits
    add(4'b0100, 4'b0100, 2'd2, 4'hA, 1'b0, 1'b1);
    add(4'b0100, 4'b0100, 2'd2, 4'hC, 1'b1, 1'b1);
    add(4'b0110, 4'b0100, 2'd2, 4'hC, 1'b1, 1'b1);
    add(4'b0110, 4'b0100, 2'd2, 4'hC, 1'b1, 1'b1);
    add(4'b0010, 4'b0000, 2'd2, 4'hC, 1'b0, 1'b1);
    add(4'b0010, 4'b0000, 2'd2, 4'hC, 1'b0, 1'b0);
    add(4'b0010, 4'b0010, 2'd1, 4'hC, 1'b0, 1'b1);
    add(4'b0010, 4'b0010, 2'd1, 4'h5, 1'b1, 1'b1);
    add(4'b0000, 4'b0000, 2'd1, 4'h5, 1'b0, 1'b1);
    add(4'b0000, 4'b0000, 2'd1, 4'h5, 1'b0, 1'b0);
    repeat (2) tick;
    chk_all("reset", 4'b0000, 2'd0, 4'h0, 1'b0, 1'b0);
    reset = 1'b0;
    foreach (vt[i]) begin
      req = vt[i].req;
      tick;
      chk_all($sformatf("v%0d", i), vt[i].grant, vt[i].sel, vt[i].bus, vt[i].valid, vt[i].busy);
    end
    // long idle keeps the last select and word
    for (int k = 0; k < 20; k++) begin
      tick;
      chk_all($sformatf("idle%0d", k), 4'b0000, 2'd1, 4'h5, 1'b0, 1'b0);
    end
    // async reset in the middle of owner 3's tenure
    req = 4'b1000;
    tick;
    chk_all("own3 grant", 4'b1000, 2'd3, 4'h5, 1'b0, 1'b1);
    tick;
    chk_all("own3 word", 4'b1000, 2'd3, 4'h3, 1'b1, 1'b1);
    #2 reset = 1'b1;
    #1 chk_all("async rst", 4'b0000, 2'd0, 4'h0, 1'b0, 1'b0);
    reset = 1'b0;
    req = 4'b1001;
    tick;
    chk_all("post rst rr", 4'b0001, 2'd0, 4'h0, 1'b0, 1'b1);
    req = 4'b0000;
    repeat (2) tick;
    chk_all("post rst idle", 4'b0000, 2'd0, 4'h0, 1'b0, 1'b0);
    // sole requester 2 holding the bus
    req = 4'b0100;
    tick;
    chk_all("hold grant", 4'b0100, 2'd2, 4'h0, 1'b0, 1'b1);
`ifdef ARB_TIMEOUT_EN
    for (int k = 0; k < 8; k++) begin
      tick;
      chk_all($sformatf("hold%0d", k), 4'b0100, 2'd2, 4'hC, 1'b1, 1'b1);
    end
    tick;
    chk_all("timeout rel", 4'b0000, 2'd2, 4'hC, 1'b0, 1'b1);
    tick;
    chk_all("timeout idle", 4'b0000, 2'd2, 4'hC, 1'b0, 1'b0);
    tick;
    chk_all("regrant", 4'b0100, 2'd2, 4'hC, 1'b0, 1'b1);
`else
    for (int k = 0; k < 12; k++) begin
      tick;
      chk_all($sformatf("hold%0d", k), 4'b0100, 2'd2, 4'hC, 1'b1, 1'b1);
    end
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
